stopwatch_up_2d: RTL and testbench

- Two-digit BCD count-up stopwatch (00..59 s) with start/pause, lap-freeze and a programmable stop target.
- Counterpart of the team's 2-digit countdown timer: it counts up from 00 to a target instead of down to 00.
- Sits between the 1 Hz tick generator and the BCD-to-7-segment display path in the stopwatch lab top level.

---
 rtl/stopwatch_up_2d.sv | 158 +++++++++++++++
 tb/tb_stopwatch_up_2d.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_up_2d.sv
// stopwatch_up_2d
//   Two-digit BCD count-up stopwatch (00..(TENS_LIMIT)9) with start/pause,
//   lap-freeze and a stop target latched when a run starts from IDLE.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   tick                  one-cycle count-enable strobe (1 Hz)
//   start_stop            one-cycle pulse: start (IDLE/PAUSE) or pause (RUN)
//   lap                   one-cycle pulse: freeze / release the display
//   clear                 one-cycle pulse: return to IDLE with count 00
//   target_d1, target_d0  stop target, BCD tens / ones
//   digit1, digit0        displayed BCD digits (lap register while frozen)
//   running, done         high in RUN / DONE respectively
//   lap_active            high while the display is frozen
module stopwatch_up_2d #(
  parameter int BCD_BIT_WIDTH = 4,
  parameter int TENS_LIMIT    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     start_stop,
  input  logic                     lap,
  input  logic                     clear,
  input  logic [BCD_BIT_WIDTH-1:0] target_d1,
  input  logic [BCD_BIT_WIDTH-1:0] target_d0,
  output logic [BCD_BIT_WIDTH-1:0] digit1,
  output logic [BCD_BIT_WIDTH-1:0] digit0,
  output logic                     running,
  output logic                     done,
  output logic                     lap_active
);

  localparam logic [BCD_BIT_WIDTH-1:0] TENS_MAX = BCD_BIT_WIDTH'(TENS_LIMIT);
  localparam logic [BCD_BIT_WIDTH-1:0] ONES_MAX = BCD_BIT_WIDTH'(9);
  localparam logic [BCD_BIT_WIDTH-1:0] ONE      = BCD_BIT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state;
  logic [BCD_BIT_WIDTH-1:0] cnt1, cnt0;
  logic [BCD_BIT_WIDTH-1:0] lap1, lap0;
  logic [BCD_BIT_WIDTH-1:0] tgt1, tgt0;
  logic                     lap_act;

  logic [BCD_BIT_WIDTH-1:0] inc1, inc0;
  logic [BCD_BIT_WIDTH-1:0] ld1, ld0;
  logic                     tgt_bad;
  logic                     hit;

  // BCD increment, saturating at (TENS_LIMIT)9 so the count can never wrap.
  always_comb begin
    inc1 = cnt1;
    inc0 = cnt0;
    if (cnt0 == ONES_MAX) begin
      if (cnt1 < TENS_MAX) begin
        inc1 = cnt1 + ONE;
        inc0 = '0;
      end
    end else begin
      inc0 = cnt0 + ONE;
    end
  end

  // Out-of-range targets are replaced by the top of the count range.
  always_comb begin
    tgt_bad = (target_d0 > ONES_MAX) || (target_d1 > TENS_MAX);
    ld1     = tgt_bad ? TENS_MAX : target_d1;
    ld0     = tgt_bad ? ONES_MAX : target_d0;
  end

  assign hit = (inc1 == tgt1) && (inc0 == tgt0);

  // Only the highest-priority effective action of a cycle is applied
  // (clear > start_stop > lap > tick); inputs a state ignores do not block
  // lower-priority ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt1    <= '0;
      cnt0    <= '0;
      lap1    <= '0;
      lap0    <= '0;
      tgt1    <= '0;
      tgt0    <= '0;
      lap_act <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_stop) begin
            tgt1  <= ld1;
            tgt0  <= ld0;
            state <= (ld1 == '0 && ld0 == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (start_stop) begin
            state <= S_PAUSE;
          end else if (lap) begin
            if (lap_act) begin
              lap_act <= 1'b0;
            end else begin
              lap1    <= cnt1;
              lap0    <= cnt0;
              lap_act <= 1'b1;
            end
          end else if (tick) begin
            cnt1 <= inc1;
            cnt0 <= inc0;
            if (hit) begin
              state   <= S_DONE;
              lap_act <= 1'b0;
            end
          end
        end
        S_PAUSE: begin
          if (clear) begin
            state   <= S_IDLE;
            cnt1    <= '0;
            cnt0    <= '0;
            lap_act <= 1'b0;
          end else if (start_stop) begin
            state <= S_RUN;
          end else if (lap) begin
            if (lap_act) begin
              lap_act <= 1'b0;
            end else begin
              lap1    <= cnt1;
              lap0    <= cnt0;
              lap_act <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (clear) begin
            state   <= S_IDLE;
            cnt1    <= '0;
            cnt0    <= '0;
            lap_act <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign digit1     = lap_act ? lap1 : cnt1;
  assign digit0     = lap_act ? lap0 : cnt0;
  assign running    = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign lap_active = lap_act;

endmodule

// File: tb/tb_stopwatch_up_2d.sv
// Testbench for stopwatch_up_2d: a constant-vector table for the basic
// run-to-target sequence, hand-written corner sequences, then randomized
// pulses checked against an integer-seconds reference model.
module tb_stopwatch_up_2d;

  logic       clk, rst, tick, start_stop, lap, clear;
  logic [3:0] target_d1, target_d0;
  logic [3:0] digit1, digit0;
  logic       running, done, lap_active;

  int checks   = 0;
  int failures = 0;

  stopwatch_up_2d #(.BCD_BIT_WIDTH(4), .TENS_LIMIT(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap),
    .clear(clear), .target_d1(target_d1), .target_d0(target_d0),
    .digit1(digit1), .digit0(digit0), .running(running), .done(done),
    .lap_active(lap_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count, lap snapshot and target as plain seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode, m_secs, m_lap_secs, m_target;
  bit m_frozen;

  function automatic void model_reset();
    m_mode = M_IDLE; m_secs = 0; m_lap_secs = 0; m_target = 0; m_frozen = 0;
  endfunction

  function automatic void model_lap();
    if (m_frozen) m_frozen = 0;
    else begin m_lap_secs = m_secs; m_frozen = 1; end
  endfunction

  function automatic void model_step(bit tk, bit ss, bit lp, bit cl, int t1, int t0);
    case (m_mode)
      M_IDLE: if (ss) begin
        m_target = (t0 > 9 || t1 > 5) ? 59 : t1 * 10 + t0;
        m_mode   = (m_target == 0) ? M_DONE : M_RUN;
      end
      M_RUN: begin
        if (ss) m_mode = M_PAUSE;
        else if (lp) model_lap();
        else if (tk) begin
          if (m_secs < 59) m_secs++;
          if (m_secs == m_target) begin m_mode = M_DONE; m_frozen = 0; end
        end
      end
      M_PAUSE: begin
        if (cl) begin m_mode = M_IDLE; m_secs = 0; m_frozen = 0; end
        else if (ss) m_mode = M_RUN;
        else if (lp) model_lap();
      end
      default: if (cl) begin m_mode = M_IDLE; m_secs = 0; m_frozen = 0; end
    endcase
  endfunction

  function automatic logic [10:0] model_out();
    int v;
    v = m_frozen ? m_lap_secs : m_secs;
    return {4'(v / 10), 4'(v % 10), m_mode == M_RUN, m_mode == M_DONE, m_frozen};
  endfunction

  function automatic logic [10:0] dut_out();
    return {digit1, digit0, running, done, lap_active};
  endfunction

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got d=%h%h run=%b done=%b lap=%b, expected d=%h%h run=%b done=%b lap=%b",
               name, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of pulses, clock, advance the model; outputs sampled #1 after the edge.
  task automatic cycle(input logic tk, input logic ss, input logic lp, input logic cl);
    tick = tk; start_stop = ss; lap = lp; clear = cl;
    @(posedge clk);
    #1;
    model_step(tk, ss, lp, cl, int'(target_d1), int'(target_d0));
    tick = 0; start_stop = 0; lap = 0; clear = 0;
  endtask

  task automatic cyc_m(input string name, input logic tk, input logic ss, input logic lp, input logic cl);
    cycle(tk, ss, lp, cl);
    chk(name, dut_out(), model_out());
  endtask

  function automatic logic [10:0] ex(input int secs, input bit r, input bit d, input bit l);
    return {4'(secs / 10), 4'(secs % 10), r, d, l};
  endfunction

  typedef struct {
    logic       tk, ss, lp, cl;
    logic [3:0] t1, t0;
    logic [3:0] e1, e0;
    logic       er, ed, el;
  } vec_t;
  vec_t vecs[9];

  initial begin
    rst = 1; tick = 0; start_stop = 0; lap = 0; clear = 0;
    target_d1 = 0; target_d0 = 0;
    model_reset();

    // Run to target 05, one extra tick, then clear.
    vecs[0] = '{0,1,0,0, 4'd0,4'd5, 4'd0,4'd0, 1,0,0};
    vecs[1] = '{1,0,0,0, 4'd0,4'd5, 4'd0,4'd1, 1,0,0};
    vecs[2] = '{1,0,0,0, 4'd0,4'd5, 4'd0,4'd2, 1,0,0};
    vecs[3] = '{1,0,0,0, 4'd0,4'd5, 4'd0,4'd3, 1,0,0};
    vecs[4] = '{1,0,0,0, 4'd0,4'd5, 4'd0,4'd4, 1,0,0};
    vecs[5] = '{1,0,0,0, 4'd0,4'd5, 4'd0,4'd5, 0,1,0};
    vecs[6] = '{1,0,0,0, 4'd0,4'd5, 4'd0,4'd5, 0,1,0};
    vecs[7] = '{0,1,1,0, 4'd0,4'd5, 4'd0,4'd5, 0,1,0};
    vecs[8] = '{0,0,0,1, 4'd0,4'd5, 4'd0,4'd0, 0,0,0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_out(), 11'd0);
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      target_d1 = vecs[i].t1; target_d0 = vecs[i].t0;
      cycle(vecs[i].tk, vecs[i].ss, vecs[i].lp, vecs[i].cl);
      chk($sformatf("vec%0d", i), dut_out(),
          {vecs[i].e1, vecs[i].e0, vecs[i].er, vecs[i].ed, vecs[i].el});
    end

    // Target 59: carries 09->10, 49->50, stop at 59 without wrapping.
    target_d1 = 5; target_d0 = 9;
    cyc_m("t59_start", 0, 1, 0, 0);
    for (int s = 1; s <= 59; s++) begin
      cycle(1, 0, 0, 0);
      if (s == 10 || s == 50) chk($sformatf("carry_%0d", s), dut_out(), ex(s, 1, 0, 0));
      else chk("t59_tick", dut_out(), model_out());
    end
    chk("t59_done", dut_out(), ex(59, 0, 1, 0));
    cycle(1, 0, 0, 0);
    chk("t59_no_wrap", dut_out(), ex(59, 0, 1, 0));
    cyc_m("t59_clear", 0, 0, 0, 1);

    // Pause with a same-cycle tick at 12.
    cyc_m("p_start", 0, 1, 0, 0);
    repeat (12) cyc_m("p_tick", 1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    chk("pause_drop_tick", dut_out(), ex(12, 0, 0, 0));
    cycle(1, 0, 0, 0);
    chk("pause_ignore_tick", dut_out(), ex(12, 0, 0, 0));
    cyc_m("resume", 0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    chk("resume_tick", dut_out(), ex(13, 1, 0, 0));

    // Lap freeze at 07 while counting continues.
    cyc_m("l_pause", 0, 1, 0, 0);
    cyc_m("l_clear", 0, 0, 0, 1);
    cyc_m("l_start", 0, 1, 0, 0);
    repeat (7) cyc_m("l_tick", 1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("lap_freeze", dut_out(), ex(7, 1, 0, 1));
    repeat (3) begin
      cycle(1, 0, 0, 0);
      chk("lap_frozen", dut_out(), ex(7, 1, 0, 1));
    end
    cycle(0, 0, 1, 0);
    chk("lap_release", dut_out(), ex(10, 1, 0, 0));

    // Target 00 goes straight to DONE; invalid 6A saturates to 59.
    cyc_m("z_pause", 0, 1, 0, 0);
    cyc_m("z_clear", 0, 0, 0, 1);
    target_d1 = 0; target_d0 = 0;
    cycle(0, 1, 0, 0);
    chk("target00_done", dut_out(), ex(0, 0, 1, 0));
    cyc_m("z_done_clear", 0, 0, 0, 1);
    target_d1 = 6; target_d0 = 4'hA;
    cyc_m("inv_start", 0, 1, 0, 0);
    repeat (59) cyc_m("inv_tick", 1, 0, 0, 0);
    chk("invalid_to_59", dut_out(), ex(59, 0, 1, 0));
    cyc_m("inv_clear", 0, 0, 0, 1);

    // Asynchronous reset mid-run at 23 with the display frozen.
    target_d1 = 5; target_d0 = 9;
    cyc_m("r_start", 0, 1, 0, 0);
    repeat (23) cyc_m("r_tick", 1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("r_lap", dut_out(), ex(23, 1, 0, 1));
    #2 rst = 1;
    #1;
    chk("async_reset", dut_out(), 11'd0);
    model_reset();
    #3 rst = 0;

    // Clear in DONE returns to IDLE at 00.
    target_d1 = 0; target_d0 = 2;
    cyc_m("c_start", 0, 1, 0, 0);
    cyc_m("c_tick", 1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("c_done", dut_out(), ex(2, 0, 1, 0));
    cycle(0, 0, 0, 1);
    chk("clear_in_done", dut_out(), ex(0, 0, 0, 0));

    // Randomized pulses against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        target_d1 = 4'($urandom_range(0, 7));
        target_d0 = 4'($urandom_range(0, 11));
      end
      cyc_m("random", 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
